// File: rtl/toy_mem_arbiter.sv
// Two-master arbiter for the single toy memory port, using round-robin grants and a fixed read latency.
// Optional build macro TOY_ARB_LOCK_EN adds input M0_LOCK, which keeps consecutive grants with M0.
module toy_mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          M0_REQ,
    input  logic          M0_RORW,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [DW-1:0] M0_WDATA,
`ifdef TOY_ARB_LOCK_EN
    input  logic          M0_LOCK,
`endif
    output logic          M0_ACK,
    input  logic          M1_REQ,
    input  logic          M1_RORW,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [DW-1:0] M1_WDATA,
    output logic          M1_ACK,
    output logic [DW-1:0] RDATA,
    output logic          GNT,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] D_OUT,
    output logic          MEM_EN,
    output logic          RORW,
    input  logic [DW-1:0] D_IN,
    output logic [1:0]    STATE
);

    // state | meaning
    // IDLE  | no transaction; arbitrate between the requests
    // ISSUE | first cycle on which the memory is enabled with the winner's address, data and direction
    // WAIT  | memory latency; the counter counts down to 1, then read data is captured
    // DONE  | bus released; the granted master's ACK pulses
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic          fav_q;
    logic          gnt_q;
    logic          mem_en_q;
    logic          rorw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] rdata_q;
    logic          ack0_q;
    logic          ack1_q;
`ifdef TOY_ARB_LOCK_EN
    logic          lock_q;
`endif

    logic req_any;
    logic lock_win;
    logic win;

    always_comb begin
        req_any  = M0_REQ | M1_REQ;
        lock_win = 1'b0;
`ifdef TOY_ARB_LOCK_EN
        lock_win = lock_q & M0_REQ;
`endif
        if (lock_win)
            win = 1'b0;
        else if (M0_REQ & M1_REQ)
            win = fav_q;
        else
            win = M1_REQ;
    end

    // The bus output registers also hold the latched transaction until the memory latency runs out.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            fav_q    <= 1'b0;
            gnt_q    <= 1'b0;
            mem_en_q <= 1'b0;
            rorw_q   <= 1'b1;
            addr_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
`ifdef TOY_ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef TOY_ARB_LOCK_EN
                    lock_q <= 1'b0;
`endif
                    if (req_any) begin
                        gnt_q    <= win;
                        if (!lock_win)
                            fav_q <= ~win;
                        mem_en_q <= 1'b1;
                        rorw_q   <= win ? M1_RORW  : M0_RORW;
                        addr_q   <= win ? M1_ADDR  : M0_ADDR;
                        dout_q   <= win ? M1_WDATA : M0_WDATA;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 3'd1) begin
                        if (rorw_q)
                            rdata_q <= D_IN;
                        mem_en_q <= 1'b0;
                        rorw_q   <= 1'b1;
                        addr_q   <= '0;
                        dout_q   <= '0;
                        ack0_q   <= ~gnt_q;
                        ack1_q   <= gnt_q;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
`ifdef TOY_ARB_LOCK_EN
                    lock_q  <= M0_LOCK & ~gnt_q;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign M0_ACK = ack0_q;
    assign M1_ACK = ack1_q;
    assign RDATA  = rdata_q;
    assign GNT    = gnt_q;
    assign ADDR   = addr_q;
    assign D_OUT  = dout_q;
    assign MEM_EN = mem_en_q;
    assign RORW   = rorw_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Bench for toy_mem_arbiter: unit A has MEM_LAT=1 and unit B has MEM_LAT=3. Both units share the requester inputs.
// A transaction-timeline model is checked against both units on every negedge, and literal expectations are checked per scenario.
module tb_toy_mem_arbiter;

`ifdef TOY_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       CLK = 1'b1;
    logic       RESET = 1'b0;
    logic       m0_req = 0, m0_rorw = 1, m1_req = 0, m1_rorw = 1, m0_lock = 0;
    logic [7:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;

    logic       ack0_a, ack1_a, gnt_a, mem_en_a, rorw_a;
    logic [7:0] rdata_a, addr_a, dout_a, din_a;
    logic [1:0] state_a;
    logic       ack0_b, ack1_b, gnt_b, mem_en_b, rorw_b;
    logic [7:0] rdata_b, addr_b, dout_b, din_b;
    logic [1:0] state_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Bench-side memories (one per unit) and the transaction-level model state.
    logic [7:0] mem [2][256];
    int         lat [2] = '{1, 3};
    bit         busy[2], own[2], mrw[2], mgnt[2], fav[2], lockp[2];
    int         t   [2];
    logic [7:0] maddr[2], mwd[2], mrd[2];

    assign din_a = mem[0][addr_a];
    assign din_b = mem[1][addr_b];

    always #5 CLK = ~CLK;

    toy_mem_arbiter #(.MEM_LAT(1), .AW(8), .DW(8)) u_a (
        .CLK(CLK), .RESET(RESET),
        .M0_REQ(m0_req), .M0_RORW(m0_rorw), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
`ifdef TOY_ARB_LOCK_EN
        .M0_LOCK(m0_lock),
`endif
        .M0_ACK(ack0_a),
        .M1_REQ(m1_req), .M1_RORW(m1_rorw), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
        .M1_ACK(ack1_a),
        .RDATA(rdata_a), .GNT(gnt_a), .ADDR(addr_a), .D_OUT(dout_a),
        .MEM_EN(mem_en_a), .RORW(rorw_a), .D_IN(din_a), .STATE(state_a)
    );

    toy_mem_arbiter #(.MEM_LAT(3), .AW(8), .DW(8)) u_b (
        .CLK(CLK), .RESET(RESET),
        .M0_REQ(m0_req), .M0_RORW(m0_rorw), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
`ifdef TOY_ARB_LOCK_EN
        .M0_LOCK(m0_lock),
`endif
        .M0_ACK(ack0_b),
        .M1_REQ(m1_req), .M1_RORW(m1_rorw), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
        .M1_ACK(ack1_b),
        .RDATA(rdata_b), .GNT(gnt_b), .ADDR(addr_b), .D_OUT(dout_b),
        .MEM_EN(mem_en_b), .RORW(rorw_b), .D_IN(din_b), .STATE(state_b)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy[i] = 0; own[i] = 0; mrw[i] = 1; mgnt[i] = 0; fav[i] = 0; lockp[i] = 0;
            t[i] = 0; maddr[i] = 0; mwd[i] = 0; mrd[i] = 0;
        end
    endtask

    // t counts cycles since the grant edge: t = 1..lat+1 memory enabled, t = lat+2 ACK, then IDLE.
    task automatic model_step(input int i);
        bit w;
        bit by_lock;
        if (busy[i]) begin
            if (t[i] == lat[i] + 1) begin
                if (mrw[i]) mrd[i] = mem[i][maddr[i]];
                else        mem[i][maddr[i]] = mwd[i];
            end
            if (t[i] == lat[i] + 2) begin
                busy[i]  = 0;
                lockp[i] = LOCK_EN && !own[i] && m0_lock;
            end else begin
                t[i]++;
            end
        end else begin
            by_lock  = lockp[i] && m0_req;
            lockp[i] = 0;
            if (m0_req || m1_req) begin
                if (by_lock)               w = 0;
                else if (m0_req && m1_req) w = fav[i];
                else                       w = m1_req;
                if (!by_lock) fav[i] = !w;
                busy[i] = 1; t[i] = 1; own[i] = w; mgnt[i] = w;
                mrw[i]   = w ? m1_rorw  : m0_rorw;
                maddr[i] = w ? m1_addr  : m0_addr;
                mwd[i]   = w ? m1_wdata : m0_wdata;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++)
                mem[i][a] = 8'(a * 7 + 3);
        mem[0][8'h05] = 8'hAA;
        mem[0][8'hFE] = 8'hFE;
        mem[1][8'hFE] = 8'hFE;
        model_reset();
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) model_reset();
            else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_unit(input int i, input logic en, input logic [7:0] ad, input logic [7:0] dout,
                            input logic rw, input logic a0, input logic a1, input logic [7:0] rd,
                            input logic g, input logic [1:0] st);
        bit   e_en;
        bit   e_ack;
        logic [1:0] e_st;
        e_en  = busy[i] && t[i] <= lat[i] + 1;
        e_ack = busy[i] && t[i] == lat[i] + 2;
        e_st  = !busy[i] ? 2'd0 : (t[i] == 1) ? 2'd1 : e_en ? 2'd2 : 2'd3;
        chk($sformatf("u%0d.MEM_EN", i), 32'(en),   32'(e_en));
        chk($sformatf("u%0d.ADDR", i),   32'(ad),   e_en ? 32'(maddr[i]) : 32'd0);
        chk($sformatf("u%0d.D_OUT", i),  32'(dout), e_en ? 32'(mwd[i]) : 32'd0);
        chk($sformatf("u%0d.RORW", i),   32'(rw),   e_en ? 32'(mrw[i]) : 32'd1);
        chk($sformatf("u%0d.M0_ACK", i), 32'(a0),   32'(e_ack && !own[i]));
        chk($sformatf("u%0d.M1_ACK", i), 32'(a1),   32'(e_ack && own[i]));
        chk($sformatf("u%0d.RDATA", i),  32'(rd),   32'(mrd[i]));
        chk($sformatf("u%0d.GNT", i),    32'(g),    32'(mgnt[i]));
        chk($sformatf("u%0d.STATE", i),  32'(st),   32'(e_st));
    endtask

    function automatic logic en_of(input int i);
        return (i == 0) ? mem_en_a : mem_en_b;
    endfunction

    function automatic logic ack_of(input int i, input bit m);
        if (i == 0) return m ? ack1_a : ack0_a;
        return m ? ack1_b : ack0_b;
    endfunction

    task automatic gap(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // k = 0 is the cycle in which the request is sampled; k_ack is the cycle in which ACK is observed.
    task automatic txn(input bit m, input bit rw, input logic [7:0] ad, input logic [7:0] wd, input int u,
                       output int k_ack, output int n_en,
                       output logic [7:0] ad1, output logic [7:0] d1, output logic rw1);
        @(posedge CLK); #1;
        if (!m) begin m0_req = 1; m0_rorw = rw; m0_addr = ad; m0_wdata = wd; end
        else    begin m1_req = 1; m1_rorw = rw; m1_addr = ad; m1_wdata = wd; end
        k_ack = 0; n_en = 0; ad1 = 0; d1 = 0; rw1 = 0;
        for (int k = 0; k <= 30 && k_ack == 0; k++) begin
            @(negedge CLK);
            if (en_of(u)) n_en++;
            if (k == 1) begin
                ad1 = (u == 0) ? addr_a : addr_b;
                d1  = (u == 0) ? dout_a : dout_b;
                rw1 = (u == 0) ? rorw_a : rorw_b;
            end
            if (ack_of(u, m)) k_ack = k;
        end
        @(posedge CLK); #1;
        if (!m) m0_req = 0; else m1_req = 0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k, n, simul;
        logic [7:0] a1, d1;
        logic       r1;
        int         q[$];
        bit         found;
        fork
            forever begin
                @(negedge CLK);
                cmp_unit(0, mem_en_a, addr_a, dout_a, rorw_a, ack0_a, ack1_a, rdata_a, gnt_a, state_a);
                cmp_unit(1, mem_en_b, addr_b, dout_b, rorw_b, ack0_b, ack1_b, rdata_b, gnt_b, state_b);
            end
            begin
                #1 RESET = 1'b1;
                #99;
                chk("rst_state",  32'(state_a),  32'd0);
                chk("rst_mem_en", 32'(mem_en_a), 32'd0);
                chk("rst_rorw",   32'(rorw_a),   32'd1);
                chk("rst_gnt",    32'(gnt_a),    32'd0);
                chk("rst_rdata",  32'(rdata_a),  32'd0);
                #35 RESET = 1'b0;
                gap(3);

                // M0 read of 0x05 returns 0xAA on unit A
                txn(0, 1, 8'h05, 8'h00, 0, k, n, a1, d1, r1);
                chk("rd_ack_lat",   32'(k),       32'd3);
                chk("rd_en_cycles", 32'(n),       32'd2);
                chk("rd_addr",      32'(a1),      32'h05);
                chk("rd_rorw",      32'(r1),      32'd1);
                chk("rd_rdata",     32'(rdata_a), 32'hAA);
                gap(12);

                // M1 write of 0x3C to 0x10
                txn(1, 0, 8'h10, 8'h3C, 0, k, n, a1, d1, r1);
                chk("wr_ack_lat", 32'(k),       32'd3);
                chk("wr_dout",    32'(d1),      32'h3C);
                chk("wr_rorw",    32'(r1),      32'd0);
                chk("wr_rdata",   32'(rdata_a), 32'hAA);
                gap(12);

                // continuous contention alternates the grants
                m0_req = 1; m0_rorw = 1; m0_addr = 8'h20;
                m1_req = 1; m1_rorw = 0; m1_addr = 8'h44; m1_wdata = 8'h5A;
                simul = 0;
                for (int c = 0; c < 24; c++) begin
                    @(negedge CLK);
                    if (ack0_a && ack1_a) simul++;
                    if (ack0_a) q.push_back(0);
                    if (ack1_a) q.push_back(1);
                end
                @(posedge CLK); #1;
                m0_req = 0; m1_req = 0;
                chk("rr_ack_count", 32'(q.size() >= 4), 32'd1);
                chk("rr_grant0", 32'(q[0]), 32'd0);
                chk("rr_grant1", 32'(q[1]), 32'd1);
                chk("rr_grant2", 32'(q[2]), 32'd0);
                chk("rr_grant3", 32'(q[3]), 32'd1);
                chk("rr_simul_ack", 32'(simul), 32'd0);
                gap(12);

                // asynchronous reset during WAIT aborts without an ACK
                m0_req = 1; m0_rorw = 1; m0_addr = 8'h05;
                found = 0;
                for (int c = 0; c < 10 && !found; c++) begin
                    @(negedge CLK);
                    if (state_a == 2'd2) found = 1;
                end
                chk("rst_reached_wait", 32'(found), 32'd1);
                #1 RESET = 1'b1;
                #1;
                chk("rst_async_mem_en", 32'(mem_en_a), 32'd0);
                chk("rst_async_state",  32'(state_a),  32'd0);
                chk("rst_async_mem_en_b", 32'(mem_en_b), 32'd0);
                m0_req = 0;
                repeat (2) @(posedge CLK);
                #3 RESET = 1'b0;
                simul = 0;
                for (int c = 0; c < 8; c++) begin
                    @(negedge CLK);
                    if (ack0_a || ack1_a) simul++;
                end
                chk("rst_no_ack", 32'(simul), 32'd0);

                // the next transaction completes normally and reads back the earlier write
                txn(1, 1, 8'h10, 8'h00, 0, k, n, a1, d1, r1);
                chk("post_rst_lat",   32'(k),       32'd3);
                chk("post_rst_rdata", 32'(rdata_a), 32'h3C);
                gap(12);

                // MEM_LAT=3 unit: M0 read of 0xFE
                txn(0, 1, 8'hFE, 8'h00, 1, k, n, a1, d1, r1);
                chk("lat3_ack_lat",   32'(k),       32'd5);
                chk("lat3_en_cycles", 32'(n),       32'd4);
                chk("lat3_rdata",     32'(rdata_b), 32'hFE);
                gap(12);

`ifdef TOY_ARB_LOCK_EN
                RESET = 1'b1;
                gap(2);
                RESET = 1'b0;
                gap(2);
                q.delete();
                m0_lock = 1;
                m0_req = 1; m0_rorw = 1; m0_addr = 8'h05;
                m1_req = 1; m1_rorw = 1; m1_addr = 8'h10;
                for (int c = 0; c < 40 && q.size() < 4; c++) begin
                    @(negedge CLK);
                    if (ack0_a) q.push_back(0);
                    if (ack1_a) q.push_back(1);
                    if (q.size() == 2 && m0_lock) begin
                        @(posedge CLK); #1;
                        m0_lock = 0;
                    end
                end
                @(posedge CLK); #1;
                m0_req = 0; m1_req = 0;
                chk("lock_grant0", 32'(q[0]), 32'd0);
                chk("lock_grant1", 32'(q[1]), 32'd0);
                chk("lock_grant2", 32'(q[2]), 32'd0);
                chk("lock_grant3", 32'(q[3]), 32'd1);
                gap(12);
`endif
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        join
    end

endmodule

// File: doc/toy_mem_arbiter.md
Name: toy_mem_arbiter

Overview:
- Shares the single toy memory port (ADDR, D_OUT, MEM_EN, RORW, D_IN) between two requesters: M0 = toy CPU (toy_sch), M1 = program loader/debug port.
- Sits between toy_sch and the memory model.
- Serialises accesses through a 4-state FSM with round-robin arbitration, fixed memory latency and a one-cycle completion ACK per requester.

Parameters:
- MEM_LAT, 1, memory read latency in cycles; legal range 1..7.
- AW, 8, address width.
- DW, 8, data width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- M0_REQ  in  1  CPU request; held until M0_ACK.
- M0_RORW  in  1  1 = read, 0 = write.
- M0_ADDR  in  AW  CPU address.
- M0_WDATA  in  DW  CPU write data.
- M0_ACK  out  1  one-cycle completion pulse.
- M1_REQ, M1_RORW, M1_ADDR, M1_WDATA, M1_ACK: same as the M0 ports, for the loader.
- RDATA  out  DW  read data, valid in the ACK cycle and held until the next read completes.
- GNT  out  1  owner of the current or last transaction (0 = M0, 1 = M1).
- ADDR  out  AW  memory address.
- D_OUT  out  DW  memory write data.
- MEM_EN  out  1  memory enable.
- RORW  out  1  memory direction, 1 = read.
- D_IN  in  DW  memory read data.
- STATE  out  2  FSM state, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE.
  - MEM_EN=0, RORW=1, ADDR=0, D_OUT=0, RDATA=0, M0_ACK=M1_ACK=0, GNT=0.
  - Round-robin pointer favours M0.
- States: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
- IDLE:
  - Only one requester active: grant it.
  - Both active: grant the one not granted last. First contention after reset goes to M0.
  - On grant, latch RORW/ADDR/WDATA of the winner, update GNT, go to ISSUE.
  - No request: stay in IDLE with MEM_EN=0.
- ISSUE (1 cycle): MEM_EN=1; ADDR, RORW and D_OUT driven from the latched values. Go to WAIT with the latency counter loaded to MEM_LAT.
- WAIT (MEM_LAT cycles): MEM_EN=1 and all bus outputs held stable. On the edge ending the last WAIT cycle:
  - read: D_IN is captured into RDATA;
  - write: RDATA is unchanged.
  - Then go to DONE.
- DONE (1 cycle):
  - MEM_EN=0; ADDR and D_OUT return to 0; RORW returns to 1.
  - ACK of the granted master is high for exactly this cycle.
  - Then go to IDLE.
- Latency: REQ sampled high at edge E → MEM_EN high for cycles E+1 .. E+1+MEM_LAT → ACK high in cycle E+2+MEM_LAT. With MEM_LAT=1, ACK is 3 cycles after sampling.
- Throughput: one transaction per MEM_LAT+3 cycles. IDLE is always visited between transactions.
- Request inputs are sampled only in IDLE. Changes to ADDR/WDATA/RORW after the grant are ignored.
- REQ dropped before ACK: the transaction still completes and ACK still pulses.
- REQ still high in the cycle after ACK: treated as a new request.
- M0_ACK and M1_ACK are never high together.
- RESET mid-transaction: aborts immediately, MEM_EN drops, no ACK is issued.

Optional Feature:
- Macro TOY_ARB_LOCK_EN.
- Defined:
  - Adds input M0_LOCK (1 bit).
  - If M0_LOCK=1 in the DONE cycle of an M0 transaction, the next IDLE cycle grants M0 when M0_REQ=1, even if M1_REQ=1. The round-robin pointer is not advanced.
  - If M0_REQ=0 in that IDLE cycle, normal arbitration applies.
- Undefined: no M0_LOCK port; pure round-robin.

Test Plan:
- Reset 135 ns, then M0 read at 0x05 with the memory returning 0xAA (MEM_LAT=1) → MEM_EN high 2 cycles with ADDR=0x05, RORW=1; M0_ACK one pulse 3 cycles after sampling; RDATA=0xAA.
- M1 write of 0x3C to 0x10 → D_OUT=0x3C, RORW=0 while MEM_EN=1; M1_ACK pulses; RDATA unchanged.
- M0 and M1 both requesting continuously → grants alternate M0, M1, M0, M1. ACKs are never simultaneous. GNT tracks the owner.
- RESET asserted during WAIT → MEM_EN=0 and STATE=0 without waiting for a clock. No ACK. The next transaction completes normally.
- MEM_LAT=3, M0 read of 0xFE → MEM_EN high 4 cycles; ACK 5 cycles after sampling; RDATA=0xFE.
- TOY_ARB_LOCK_EN defined, M0_LOCK=1, both requesting → M0 granted on 3 consecutive transactions. After M0_LOCK=0, the next contention goes to M1.
